// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide on magnitudes.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiplier with a single-cycle one.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    // state | meaning
    // IDLE  | waiting for a request, in_ready high unless flushing
    // CALC  | one radix-2 step per cycle, then a final sign-fixup cycle
    // DONE  | result held with out_valid until out_ready

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MUL   = 3'd0;
    localparam logic [2:0] OP_MULH  = 3'd1;
    localparam logic [2:0] OP_MULHU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_MOD   = 3'd4;
    localparam logic [2:0] OP_DIVU  = 3'd5;
    localparam logic [2:0] OP_MODU  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             fin_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] src1_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] low_q;
    logic [WIDTH-1:0] opd_q;
    logic             div_zero_q;
    logic             neg_res_q;
    logic             neg_rem_q;

    logic             in_is_mul;
    logic             in_signed;
    logic             s1_neg;
    logic             s2_neg;
    logic [WIDTH-1:0] s1_mag;
    logic [WIDTH-1:0] s2_mag;

    logic             is_mul_q;
    logic             fast_done;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_sub;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] res_next;

    assign in_ready = (state_q == S_IDLE) && !flush;

    // Request decode: op 7 rides the multiplier path so it shares MUL latency.
    always_comb begin
        in_is_mul = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHU) || (op == OP_RSVD);
        in_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_MOD);
        s1_neg    = in_signed && src1[WIDTH-1];
        s2_neg    = in_signed && src2[WIDTH-1];
        s1_mag    = s1_neg ? -src1 : src1;
        s2_mag    = s2_neg ? -src2 : src2;
    end

    always_comb begin
        is_mul_q = (op_q == OP_MUL) || (op_q == OP_MULH) || (op_q == OP_MULHU) || (op_q == OP_RSVD);
        mul_sum  = {1'b0, acc_q} + (low_q[0] ? {1'b0, opd_q} : '0);
        rem_sh   = {acc_q, low_q[WIDTH-1]};
        rem_ge   = rem_sh >= {1'b0, opd_q};
        // Remainder stays below the divisor, so the W-bit difference is exact.
        rem_sub  = rem_sh[WIDTH-1:0] - opd_q;
`ifdef MULDIV_FAST_MUL_EN
        fast_done = is_mul_q;
        prod      = {{WIDTH{1'b0}}, opd_q} * {{WIDTH{1'b0}}, low_q};
`else
        fast_done = 1'b0;
        prod      = {acc_q, low_q};
`endif
        prod_fix = neg_res_q ? -prod : prod;
        quo_fix  = neg_res_q ? -low_q : low_q;
        rem_fix  = neg_rem_q ? -acc_q : acc_q;
    end

    always_comb begin
        res_next = '0;
        case (op_q)
            OP_MUL:   res_next = prod_fix[WIDTH-1:0];
            OP_MULH:  res_next = prod_fix[2*WIDTH-1:WIDTH];
            OP_MULHU: res_next = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV:   res_next = div_zero_q ? '1 : quo_fix;
            OP_DIVU:  res_next = div_zero_q ? '1 : quo_fix;
            OP_MOD:   res_next = div_zero_q ? src1_q : rem_fix;
            OP_MODU:  res_next = div_zero_q ? src1_q : rem_fix;
            default:  res_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            fin_q      <= 1'b0;
            op_q       <= '0;
            src1_q     <= '0;
            acc_q      <= '0;
            low_q      <= '0;
            opd_q      <= '0;
            div_zero_q <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            out_valid  <= 1'b0;
            result     <= '0;
            busy       <= 1'b0;
        end else if (flush) begin
            state_q   <= S_IDLE;
            fin_q     <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            busy      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        state_q    <= S_CALC;
                        busy       <= 1'b1;
                        cnt_q      <= CW'(WIDTH - 1);
                        fin_q      <= 1'b0;
                        op_q       <= op;
                        src1_q     <= src1;
                        acc_q      <= '0;
                        low_q      <= in_is_mul ? s2_mag : s1_mag;
                        opd_q      <= in_is_mul ? s1_mag : s2_mag;
                        div_zero_q <= (src2 == '0);
                        neg_res_q  <= s1_neg ^ s2_neg;
                        neg_rem_q  <= s1_neg;
                    end
                end
                S_CALC: begin
                    if (fin_q || fast_done) begin
                        state_q   <= S_DONE;
                        fin_q     <= 1'b0;
                        out_valid <= 1'b1;
                        result    <= res_next;
                    end else begin
                        if (is_mul_q) begin
                            acc_q <= mul_sum[WIDTH:1];
                            low_q <= {mul_sum[0], low_q[WIDTH-1:1]};
                        end else if (rem_ge) begin
                            acc_q <= rem_sub;
                            low_q <= {low_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_q <= rem_sh[WIDTH-1:0];
                            low_q <= {low_q[WIDTH-2:0], 1'b0};
                        end
                        if (cnt_q == '0) begin
                            fin_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q   <= S_IDLE;
                        out_valid <= 1'b0;
                        result    <= '0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
